uart_tx_ctrl: RTL and testbench

Transmit-side controller and serializer for the UART TX path. Accepts a parallel byte with a valid strobe, computes optional even/odd parity, and sequences the frame start → data (LSB first) → parity → stop. It drives the 2-bit select and the data/parity bit inputs of the registered 4:1 TX output mux directly downstream. It runs on the TX bit clock: one clock cycle is one bit period.

---
 rtl/uart_tx_ctrl.sv | 96 +++++++++
 tb/tb_uart_tx_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel payload as start, data (LSB first), optional
// parity and stop, and drives the select and data/parity inputs of the registered TX mux.
module uart_tx_ctrl #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [1:0]            MUX_SEL,
   output logic                  SER_DATA,
   output logic                  PAR_BIT,
   output logic                  BUSY
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         shift_q   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      MUX_SEL   = 2'b01;
      BUSY      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (DATA_VALID) begin
               shift_d   = P_DATA;
               par_en_d  = PAR_EN;
               // Parity type only matters here, so it is folded into the registered bit.
               par_bit_d = (^P_DATA) ^ PAR_TYP;
               state_d   = StStart;
            end
         end
         StStart: begin
            MUX_SEL = 2'b00;
            BUSY    = 1'b1;
            cnt_d   = '0;
            state_d = StData;
         end
         StData: begin
            MUX_SEL = 2'b10;
            BUSY    = 1'b1;
            shift_d = shift_q >> 1;
            if (cnt_q == CntLast) begin
               state_d = par_en_q ? StParity : StStop;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StParity: begin
            MUX_SEL = 2'b11;
            BUSY    = 1'b1;
            state_d = StStop;
         end
         StStop: begin
            MUX_SEL = 2'b01;
            BUSY    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign SER_DATA = shift_q[0];
   assign PAR_BIT  = par_bit_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a frame-level queue model predicts every cycle's
// mux select, busy, data and parity bit, plus the downstream registered line.
module tb_uart_tx_ctrl;

   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [DW-1:0] P_DATA = '0;
   logic          DATA_VALID = 1'b0;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic [1:0]    MUX_SEL;
   logic          SER_DATA;
   logic          PAR_BIT;
   logic          BUSY;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [1:0] sel;
      logic       ser;
   } item_t;

   item_t exp_q[$];
   logic  exp_par  = 1'b0;
   logic  exp_line = 1'b1;
   logic  line_q;
   int    busy_cnt = 0;
   int    n_accepts = 0;

   always #5 CLK = ~CLK;

   uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .MUX_SEL    (MUX_SEL),
      .SER_DATA   (SER_DATA),
      .PAR_BIT    (PAR_BIT),
      .BUSY       (BUSY)
   );

   // Downstream registered 4:1 mux.
   always @(posedge CLK or negedge RST) begin
      if (!RST) line_q <= 1'b1;
      else begin
         case (MUX_SEL)
            2'b00:   line_q <= 1'b0;
            2'b01:   line_q <= 1'b1;
            2'b10:   line_q <= SER_DATA;
            default: line_q <= PAR_BIT;
         endcase
      end
   end

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_sel"}, 8'(MUX_SEL), 8'h01);
      check_val({tag, "_busy"}, 8'(BUSY), 8'h00);
      check_val({tag, "_ser"}, 8'(SER_DATA), 8'h00);
      check_val({tag, "_par"}, 8'(PAR_BIT), 8'h00);
   endtask

   // Frame expectation built straight from the frame format.
   task automatic model_edge();
      if (exp_q.size() == 0) begin
         if (DATA_VALID) begin
            n_accepts++;
            exp_q.push_back('{sel: 2'b00, ser: 1'b0});
            for (int i = 0; i < DW; i++) exp_q.push_back('{sel: 2'b10, ser: P_DATA[i]});
            if (PAR_EN) exp_q.push_back('{sel: 2'b11, ser: 1'b0});
            exp_q.push_back('{sel: 2'b01, ser: 1'b0});
            exp_par = (^P_DATA) ^ PAR_TYP;
         end
      end else begin
         void'(exp_q.pop_front());
      end
   endtask

   task automatic tick();
      item_t it;
      model_edge();
      @(posedge CLK);
      #1;
      check_val("line", 8'(line_q), 8'(exp_line));
      check_val("par_bit", 8'(PAR_BIT), 8'(exp_par));
      if (BUSY) busy_cnt++;
      if (exp_q.size() == 0) begin
         check_val("idle_sel", 8'(MUX_SEL), 8'h01);
         check_val("idle_busy", 8'(BUSY), 8'h00);
         exp_line = 1'b1;
      end else begin
         it = exp_q[0];
         check_val("sel", 8'(MUX_SEL), 8'(it.sel));
         check_val("busy", 8'(BUSY), 8'h01);
         if (it.sel == 2'b10) check_val("ser", 8'(SER_DATA), 8'(it.ser));
         case (it.sel)
            2'b00:   exp_line = 1'b0;
            2'b01:   exp_line = 1'b1;
            2'b10:   exp_line = it.ser;
            default: exp_line = exp_par;
         endcase
      end
   endtask

   task automatic flush();
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
      check_val("flush_done", 8'(exp_q.size()), 8'h00);
   endtask

   task automatic send(input logic [7:0] d, input logic pen, input logic ptyp);
      P_DATA     = d;
      PAR_EN     = pen;
      PAR_TYP    = ptyp;
      DATA_VALID = 1'b1;
      busy_cnt   = 0;
      tick();
      DATA_VALID = 1'b0;
      flush();
      check_val("busy_len", 8'(busy_cnt), pen ? 8'(DW + 3) : 8'(DW + 2));
   endtask

   task automatic reset_now();
      RST = 1'b0;
      #1;
      exp_q.delete();
      exp_par  = 1'b0;
      exp_line = 1'b1;
   endtask

   initial begin
      int gap;
      // Reset held with random inputs.
      for (int i = 0; i < 4; i++) begin
         P_DATA     = DW'($urandom);
         DATA_VALID = 1'($urandom);
         PAR_EN     = 1'($urandom);
         PAR_TYP    = 1'($urandom);
         @(posedge CLK);
         #1;
         check_reset_vals("rst_hold");
      end
      DATA_VALID = 1'b0;
      RST        = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("post_rst_ser", 8'(SER_DATA), 8'h00);
      end

      send(8'hA5, 1'b0, 1'b0);
      send(8'hA5, 1'b1, 1'b0);
      check_val("par_a5_even", 8'(PAR_BIT), 8'h00);
      send(8'hA5, 1'b1, 1'b1);
      check_val("par_a5_odd", 8'(PAR_BIT), 8'h01);
      send(8'h07, 1'b1, 1'b0);
      check_val("par_07_even", 8'(PAR_BIT), 8'h01);

      // Disturbance during DATA of a 0x3C frame.
      P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      busy_cnt = 0;
      tick();
      DATA_VALID = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
      tick();
      DATA_VALID = 1'b0;
      flush();
      check_val("dist_busy_len", 8'(busy_cnt), 8'(DW + 3));
      check_val("dist_par", 8'(PAR_BIT), 8'h00);
      for (int i = 0; i < 3; i++) tick();

      // Back-to-back with DATA_VALID held.
      n_accepts = 0;
      gap = 0;
      P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      tick();
      P_DATA = 8'hAA;
      for (int i = 0; i < 30 && n_accepts < 2; i++) begin
         tick();
         if (!BUSY) gap++;
      end
      check_val("b2b_accepts", 8'(n_accepts), 8'h02);
      check_val("b2b_gap", 8'(gap), 8'h01);
      DATA_VALID = 1'b0;
      flush();

      // Reset at data bit 3.
      P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
      tick();
      DATA_VALID = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check_val("pre_rst_sel", 8'(MUX_SEL), 8'h02);
      reset_now();
      check_reset_vals("mid_rst");
      @(posedge CLK);
      #1;
      check_reset_vals("mid_rst_hold");
      RST = 1'b1;
      tick();
      send(8'h81, 1'b1, 1'b0);
      check_val("par_81", 8'(PAR_BIT), 8'h00);

      // Randomized traffic with mid-frame input churn.
      for (int i = 0; i < 800; i++) begin
         DATA_VALID = ($urandom_range(0, 3) == 0);
         P_DATA     = DW'($urandom);
         PAR_EN     = 1'($urandom);
         PAR_TYP    = 1'($urandom);
         tick();
      end
      DATA_VALID = 1'b0;
      flush();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
